mem_arbiter: RTL and testbench

Arbitrates between the fetch stage's instruction port and the memory stage's data port so both share one unified, variable-latency memory port. It serialises accesses with one transaction outstanding and holds captured address and data stable toward memory. It returns a one-cycle done pulse with read data to the owning requester. The pipeline derives its fetch and memory stalls from `req & ~done`.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_starve_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the instruction/data memory arbiter
package mem_arb_pkg;

   // Arbiter sequencing: pick a winner, present it, wait for the response, pulse done
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Which requester owns the transaction in flight
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Consecutive data grants allowed to bypass a waiting instruction fetch
   localparam int STARVE_LIMIT_DEF = 2;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of data grants made over a waiting fetch
module arb_starve_counter #(
   parameter int LIMIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   assign at_limit = (count == W'(LIMIT));

   // Clear wins over increment; the count never passes LIMIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one variable-latency memory port between fetch and data stages
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   state_t state;
   state_t state_n;
   owner_t owner;
   logic   grant_i;
   logic   grant_d;
   logic   starve_inc;
   logic   starve_clr;
   logic   at_limit;

   arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .at_limit (at_limit)
   );

   // Next state and winner selection; grants are only made from IDLE
   always_comb begin
      state_n    = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(i_req && at_limit)) begin
               grant_d = 1'b1;
            end else if (i_req) begin
               grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_n = REQ;
            end
            starve_inc = grant_d && i_req;
            starve_clr = grant_i || !i_req;
         end
         REQ:     if (mem_gnt)    state_n = WAIT;
         WAIT:    if (mem_rvalid) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Registered memory-side request, captured transaction and per-owner responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_I;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         mem_req <= (state_n == REQ);
         if (grant_d) begin
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grant_i) begin
            owner     <= OWN_I;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
         end
         if (state == WAIT && mem_rvalid) begin
            if (owner == OWN_I) begin
               i_done  <= 1'b1;
               i_rdata <= mem_rdata;
            end else begin
               d_done <= 1'b1;
               // A store acknowledge carries no data for the requester
               if (!mem_we) begin
                  d_rdata <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int LIM = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_done     (i_done),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_done     (d_done),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},   mem_req,   0);
      chk({tag, "_mem_we"},    mem_we,    0);
      chk({tag, "_mem_addr"},  mem_addr,  0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_i_done"},    i_done,    0);
      chk({tag, "_d_done"},    d_done,    0);
      chk({tag, "_i_rdata"},   i_rdata,   0);
      chk({tag, "_d_rdata"},   d_rdata,   0);
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic        e_idone;
      logic [31:0] e_irdata;
      logic        e_ddone;
      logic [31:0] e_drdata;
   } vec_t;

   vec_t tbl [12];

   // Random-test reference model state
   logic [31:0] mem_m [logic [31:0]];
   int          cnt;
   logic        busy;
   int          tg, g, r, t_end, o;
   logic        own_d, x_we;
   logic [31:0] x_addr, x_wdata, x_rdata, exp_ir, exp_dr;
   logic        rv_window;

   // Starvation / misc sequence state
   logic [31:0] order [6];
   int          got;
   logic        prev_req, gnt_prev;
   logic [31:0] exp_order [6];

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem_m.exists(a) ? mem_m[a] : (a ^ 32'h5A5A_0000);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      do_reset();
      chk_all_zero("reset");

      // ---- table: single fetch, stray response in RESP, simultaneous I + D store ----
      //            ireq iaddr        dreq dwe daddr  dwdata        gnt rv rdata           mreq we maddr  mwdata        idone irdata          ddone drdata
      tbl[0]  = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,   32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      tbl[1]  = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4,   32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      tbl[2]  = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h00500093,  1'b0, 1'b0, 32'h4,   32'h0,         1'b1, 32'h00500093,  1'b0, 32'h0};
      tbl[3]  = '{1'b0, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 32'h4,   32'h0,         1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,  32'hDEADBEEF,  1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[5]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40,  32'hDEADBEEF,  1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[6]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF,  1'b0, 1'b1, 32'h11111111,  1'b0, 1'b1, 32'h40,  32'hDEADBEEF,  1'b0, 32'h00500093,  1'b1, 32'h0};
      tbl[7]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40,  32'hDEADBEEF,  1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[8]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h100, 32'h0,         1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h100, 32'h0,         1'b0, 32'h00500093,  1'b0, 32'h0};
      tbl[10] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hCAFEF00D,  1'b0, 1'b0, 32'h100, 32'h0,         1'b1, 32'hCAFEF00D,  1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h100, 32'h0,         1'b0, 32'hCAFEF00D,  1'b0, 32'h0};

      for (int v = 0; v < 12; v++) begin
         i_req = tbl[v].ireq; i_addr = tbl[v].iaddr;
         d_req = tbl[v].dreq; d_we = tbl[v].dwe; d_addr = tbl[v].daddr; d_wdata = tbl[v].dwdata;
         mem_gnt = tbl[v].gnt; mem_rvalid = tbl[v].rv; mem_rdata = tbl[v].rdata;
         step();
         chk($sformatf("vec%0d_mem_req", v),   mem_req,   tbl[v].e_mreq);
         chk($sformatf("vec%0d_mem_we", v),    mem_we,    tbl[v].e_mwe);
         chk($sformatf("vec%0d_mem_addr", v),  mem_addr,  tbl[v].e_maddr);
         chk($sformatf("vec%0d_mem_wdata", v), mem_wdata, tbl[v].e_mwdata);
         chk($sformatf("vec%0d_i_done", v),    i_done,    tbl[v].e_idone);
         chk($sformatf("vec%0d_i_rdata", v),   i_rdata,   tbl[v].e_irdata);
         chk($sformatf("vec%0d_d_done", v),    d_done,    tbl[v].e_ddone);
         chk($sformatf("vec%0d_d_rdata", v),   d_rdata,   tbl[v].e_drdata);
      end

      // ---- starvation: both requesting continuously, zero-wait memory ----
      do_reset();
      i_req = 1; i_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
      exp_order = '{32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
      got = 0; prev_req = 0; gnt_prev = 0;
      for (int c = 0; c < 80 && got < 6; c++) begin
         mem_gnt    = mem_req;
         mem_rvalid = gnt_prev;
         mem_rdata  = 32'(c);
         gnt_prev   = mem_gnt;
         step();
         if (mem_req && !prev_req) begin
            order[got] = mem_addr;
            got++;
         end
         prev_req = mem_req;
      end
      chk("starve_grant_count", 32'(got), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < got) chk($sformatf("starve_grant%0d", k), order[k], exp_order[k]);
      end

      // ---- wait states: gnt 3 cycles late, rvalid 4 cycles after gnt ----
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h80;
      for (int c = 0; c < 14; c++) begin
         mem_gnt    = (c == 4);
         mem_rvalid = (c == 8);
         mem_rdata  = (c == 8) ? 32'h12345678 : 32'hBAD0BAD0;
         if (c >= 1) d_addr = 32'hFFFF0000 + 32'(c);
         if (c >= 9) d_req = 0;
         step();
         o = c + 1;
         chk($sformatf("ws_mem_req_c%0d", o),  mem_req,  32'(o >= 1 && o <= 4));
         chk($sformatf("ws_mem_addr_c%0d", o), mem_addr, 32'h80);
         chk($sformatf("ws_d_done_c%0d", o),   d_done,   32'(o == 9));
         if (o >= 9) chk($sformatf("ws_d_rdata_c%0d", o), d_rdata, 32'h12345678);
      end

      // ---- reset while in WAIT, then late response and a fresh fetch ----
      do_reset();
      d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hA5A5A5A5;
      step();
      mem_gnt = 1;
      step();
      mem_gnt = 0; d_req = 0;
      chk("rw_pre_mem_we", mem_we, 1);
      #2 rst = 1;
      #1;
      chk_all_zero("rw_async");
      step();
      rst = 0;
      i_req = 1; i_addr = 32'h200; mem_rvalid = 1; mem_rdata = 32'h77777777;
      step();
      chk("rw_mem_req_c1", mem_req, 1);
      chk("rw_mem_addr_c1", mem_addr, 32'h200);
      chk("rw_mem_we_c1", mem_we, 0);
      chk("rw_d_done_c1", d_done, 0);
      mem_rvalid = 0; mem_gnt = 1;
      step();
      chk("rw_mem_req_c2", mem_req, 0);
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13579BDF;
      step();
      chk("rw_i_done_c3", i_done, 1);
      chk("rw_i_rdata_c3", i_rdata, 32'h13579BDF);
      chk("rw_d_rdata_c3", d_rdata, 0);
      i_req = 0; mem_rvalid = 0;
      step();
      chk("rw_i_done_c4", i_done, 0);

      // ---- requester drops d_req during WAIT ----
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h90;
      step();
      chk("drop_mem_req_c1", mem_req, 1);
      mem_gnt = 1;
      step();
      mem_gnt = 0; d_req = 0;
      step();
      chk("drop_d_done_c3", d_done, 0);
      mem_rvalid = 1; mem_rdata = 32'h0BADCAFE;
      step();
      chk("drop_d_done_c4", d_done, 1);
      chk("drop_d_rdata_c4", d_rdata, 32'h0BADCAFE);
      mem_rvalid = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("drop_no_rereq%0d", c), mem_req, 0);
         chk($sformatf("drop_no_done%0d", c), d_done, 0);
      end

      // ---- randomized traffic against a transaction-timeline model ----
      do_reset();
      cnt = 0; busy = 0; exp_ir = 0; exp_dr = 0;
      tg = 0; g = 0; r = 0; t_end = -1;
      own_d = 0; x_we = 0; x_addr = 0; x_wdata = 0; x_rdata = 0;
      for (int k = 0; k < 3000; k++) begin
         i_req   = i_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
         d_req   = d_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
         i_addr  = 32'($urandom_range(0, 15)) << 2;
         d_addr  = 32'($urandom_range(0, 15)) << 2;
         d_we    = ($urandom_range(0, 1) == 1);
         d_wdata = $urandom;
         if (busy && k > t_end) busy = 0;
         if (!busy) begin
            // Data first, unless the fetch has already been passed over LIM times
            if (d_req && !(i_req && cnt == LIM)) begin
               own_d = 1; x_addr = d_addr; x_we = d_we; x_wdata = d_wdata;
               cnt = i_req ? ((cnt < LIM) ? cnt + 1 : cnt) : 0;
               busy = 1;
            end else if (i_req) begin
               own_d = 0; x_addr = i_addr; x_we = 0; x_wdata = 0;
               cnt = 0;
               busy = 1;
            end else begin
               cnt = 0;
            end
            if (busy) begin
               tg = k; g = $urandom_range(0, 3); r = $urandom_range(0, 3);
               t_end = tg + 3 + g + r;
            end
         end
         mem_gnt   = busy && (k == tg + 1 + g);
         rv_window = busy && (k >= tg + 2 + g) && (k <= tg + 2 + g + r);
         mem_rdata = $urandom;
         if (busy && k == tg + 2 + g + r) begin
            mem_rvalid = 1;
            if (x_we) begin
               mem_m[x_addr] = x_wdata;
            end else begin
               mem_rdata = rd(x_addr);
               x_rdata   = mem_rdata;
            end
         end else begin
            mem_rvalid = rv_window ? 1'b0 : ($urandom_range(0, 3) == 0);
         end
         step();
         o = k + 1;
         if (busy && o == t_end) begin
            if (!own_d) exp_ir = x_rdata;
            else if (!x_we) exp_dr = x_rdata;
         end
         chk("rnd_mem_req", mem_req, 32'(busy && o >= tg + 1 && o <= tg + 1 + g));
         if (busy && o >= tg + 1) begin
            chk("rnd_mem_addr", mem_addr, x_addr);
            chk("rnd_mem_we", mem_we, 32'(x_we));
            chk("rnd_mem_wdata", mem_wdata, x_wdata);
         end
         chk("rnd_i_done", i_done, 32'(busy && o == t_end && !own_d));
         chk("rnd_d_done", d_done, 32'(busy && o == t_end && own_d));
         chk("rnd_i_rdata", i_rdata, exp_ir);
         chk("rnd_d_rdata", d_rdata, exp_dr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
